fifo_burst_reader: RTL

Read-side controller for the synchronous 8-bit FIFO. On a start command it pops a programmed number of words from the FIFO's `re`/`dout`/`empty` port and presents each word on a valid/ready output stream. It accumulates a modular checksum of the words it delivers. It sits between the FIFO and any downstream consumer (serializer, packetizer), as the counterpart to the FIFO writer.

---
 rtl/fifo_burst_reader_if.sv | 35 +++
 rtl/fifo_burst_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, its source FIFO read port
// and the downstream valid/ready consumer.
interface fifo_burst_reader_if #(
    parameter int DW = 8
);
    // FIFO read port
    logic          fifo_empty;
    logic          fifo_re;
    logic [DW-1:0] fifo_dout;

    // Output word stream
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    // Seen from the burst reader
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_ready,
        output fifo_re,
        output out_data,
        output out_valid
    );

    // Seen from the FIFO / consumer side
    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_ready,
        input  fifo_re,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: on a start command pops `len` words from a synchronous
// FIFO, presents each on a valid/ready stream and keeps a wrap-around sum of
// the delivered words.
// Optional feature: define FIFO_BURST_READER_TIMEOUT_EN to abort a burst with
// err=1 after TO_CYCLES consecutive empty cycles while fetching. Without it
// the fetch waits forever and err is tied low.
module fifo_burst_reader #(
    parameter int DW        = 8,
    parameter int LEN_W     = 5,
    parameter int TO_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [DW-1:0]    sum,
    fifo_burst_reader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    // Checksum accumulation wraps modulo 2^DW.
    function automatic logic [DW-1:0] add_wrap(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        return a + b;
    endfunction

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    sum_q, sum_d;
    logic [DW-1:0]    data_q, data_d;
    logic             valid_q, valid_d;
    logic             fifo_re_c;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES + 1) : 1;

    logic            err_q, err_d;
    logic [TO_W-1:0] stall_q, stall_d;
`else
    // TO_CYCLES only matters when the timeout is built.
    logic unused_to_cfg;
    assign unused_to_cfg = (TO_CYCLES != 0);
`endif

    // Next-state and datapath decisions; every target defaults to hold.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fifo_re_c = 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        err_d     = err_q;
        stall_d   = stall_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sum_d = '0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (len != '0) begin
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = S_FETCH;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                        stall_d = '0;
`endif
                    end else begin
                        // Zero-length burst: finish without touching the FIFO.
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                // Reading only when non-empty makes an overread impossible.
                if (!bus.fifo_empty) begin
                    fifo_re_c = 1'b1;
                    state_d   = S_CAPT;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                    stall_d   = '0;
                end else if (stall_q == TO_W'(TO_CYCLES - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    stall_d = stall_q + TO_W'(1);
`endif
                end
            end
            S_CAPT: begin
                // FIFO data is valid the cycle after the read strobe.
                data_d  = bus.fifo_dout;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + LEN_W'(1);
                    sum_d   = add_wrap(sum_q, data_q);
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                        stall_d = '0;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // Timeout bookkeeping: stall counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy          = (state_q == S_FETCH) || (state_q == S_CAPT) || (state_q == S_SEND);
    assign done          = (state_q == S_DONE);
    assign sum           = sum_q;
    assign bus.fifo_re   = fifo_re_c;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;

endmodule
